// File: rtl/gray_frame_sequencer_if.sv
// -----------------------------------------------------------------------------
// gray_frame_sequencer_if
// Groups the two streaming handshakes seen by the frame sequencer:
//   src_*  : RGB pixels arriving from the upstream source
//   m_*    : grayscale pixels leaving towards the downstream sink
// Modports:
//   master : the sequencer's view (accepts src, drives the sink stream)
//   slave  : the environment's view (drives src, consumes the sink stream)
// -----------------------------------------------------------------------------
interface gray_frame_sequencer_if #(
   parameter int PIX_W  = 24,
   parameter int GRAY_W = 8
);
   logic              src_valid;
   logic              src_ready;
   logic [PIX_W-1:0]  src_data;
   logic              m_valid;
   logic              m_ready;
   logic [GRAY_W-1:0] m_data;
   logic              m_last;

   modport master (
      input  src_valid, src_data, m_ready,
      output src_ready, m_valid, m_data, m_last
   );

   modport slave (
      output src_valid, src_data, m_ready,
      input  src_ready, m_valid, m_data, m_last
   );
endinterface

// File: rtl/gray_frame_sequencer.sv
// -----------------------------------------------------------------------------
// gray_frame_sequencer
// Frame-level controller for the grayscale pipeline. Admits a programmed
// number of RGB pixels into a fixed-latency conversion pipe, buffers the
// converted pixels in a credit-managed FIFO and hands them to the sink.
// Ports:
//   ACLK, ARESETN        clock, asynchronous active-low reset
//   cfg_start/abort      one-cycle command pulses from the register bank
//   cfg_num_pixels       frame length, sampled on an accepted start
//   sts_busy/done/aborted, sts_out_count, irq   status back to the bank
//   stream (master)      src_* upstream handshake, m_* downstream handshake
//   pipe_in_*            pixel issued into the conversion pipe
//   pipe_out_*           converted pixel returned by the pipe (no stall)
// -----------------------------------------------------------------------------
module gray_frame_sequencer #(
   parameter int PIX_W      = 24,
   parameter int GRAY_W     = 8,
   parameter int CNT_W      = 20,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                   ACLK,
   input  logic                   ARESETN,
   input  logic                   cfg_start,
   input  logic                   cfg_abort,
   input  logic [CNT_W-1:0]       cfg_num_pixels,
   output logic                   sts_busy,
   output logic                   sts_done,
   output logic                   sts_aborted,
   output logic [CNT_W-1:0]       sts_out_count,
   output logic                   irq,
   gray_frame_sequencer_if.master stream,
   output logic                   pipe_in_valid,
   output logic [PIX_W-1:0]       pipe_in_data,
   input  logic                   pipe_out_valid,
   input  logic [GRAY_W-1:0]      pipe_out_data
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0]      DEPTH_V = (CW+1)'(FIFO_DEPTH);
   localparam logic [CW-1:0]    CW_ONE  = 1;
   localparam logic [AW-1:0]    AW_ONE  = 1;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  num;
   logic [CNT_W-1:0]  issued;
   logic [CNT_W-1:0]  out_count;
   logic [CW-1:0]     in_flight;
   logic [CW-1:0]     fifo_count;
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [GRAY_W-1:0] mem [FIFO_DEPTH];

   logic [CW:0] credit_used;
   logic        running;
   logic        src_fire;
   logic        push;
   logic        pop;
   logic        abort_hit;
   logic        start_hit;

   assign running   = (state == S_RUN) || (state == S_DRAIN);
   assign start_hit = cfg_start && (state == S_IDLE);
   assign abort_hit = cfg_abort && running;

   // Every pixel in the pipe already owns a FIFO slot, so admitting a new one
   // only when pipe + FIFO occupancy is below the depth makes overflow
   // impossible even though the pipe itself cannot be stalled.
   assign credit_used      = {1'b0, in_flight} + {1'b0, fifo_count};
   assign stream.src_ready = (state == S_RUN) && (credit_used < DEPTH_V);
   assign src_fire         = stream.src_valid && stream.src_ready;

   assign pipe_in_valid = src_fire;
   assign pipe_in_data  = stream.src_data;

   // Head data is masked while invalid so the sink never sees stale entries.
   assign stream.m_valid = running && (fifo_count != '0);
   assign stream.m_data  = stream.m_valid ? mem[rd_ptr] : '0;
   assign stream.m_last  = stream.m_valid && (out_count == (num - CNT_ONE));

   assign pop  = stream.m_valid && stream.m_ready;
   assign push = pipe_out_valid && (state != S_FLUSH);

   assign irq           = (state == S_DONE) || abort_hit;
   assign sts_busy      = running || (state == S_FLUSH);
   assign sts_out_count = out_count;

   // FIFO storage is not reset; occupancy is tracked by fifo_count alone.
   always_ff @(posedge ACLK) begin
      if (push) begin
         mem[wr_ptr] <= pipe_out_data;
      end
   end

   // Frame FSM together with the counters and FIFO pointers it governs.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state       <= S_IDLE;
         num         <= '0;
         issued      <= '0;
         out_count   <= '0;
         in_flight   <= '0;
         fifo_count  <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         sts_done    <= 1'b0;
         sts_aborted <= 1'b0;
      end else begin
         if (src_fire && !pipe_out_valid) begin
            in_flight <= in_flight + CW_ONE;
         end else if (!src_fire && pipe_out_valid) begin
            in_flight <= in_flight - CW_ONE;
         end

         // Abort empties the FIFO outright, overriding any push or pop.
         if (abort_hit) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + AW_ONE;
            end
            if (pop) begin
               rd_ptr <= rd_ptr + AW_ONE;
            end
            if (push && !pop) begin
               fifo_count <= fifo_count + CW_ONE;
            end else if (!push && pop) begin
               fifo_count <= fifo_count - CW_ONE;
            end
         end

         if (pop) begin
            out_count <= out_count + CNT_ONE;
         end
         if (src_fire) begin
            issued <= issued + CNT_ONE;
         end

         case (state)
            S_IDLE: begin
               if (start_hit) begin
                  num         <= cfg_num_pixels;
                  issued      <= '0;
                  out_count   <= '0;
                  sts_done    <= 1'b0;
                  sts_aborted <= 1'b0;
                  state       <= (cfg_num_pixels == '0) ? S_DONE : S_RUN;
               end
            end
            S_RUN: begin
               if (abort_hit) begin
                  sts_aborted <= 1'b1;
                  state       <= S_FLUSH;
               end else if (src_fire && ((issued + CNT_ONE) == num)) begin
                  state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (abort_hit) begin
                  sts_aborted <= 1'b1;
                  state       <= S_FLUSH;
               end else if (pop && ((out_count + CNT_ONE) == num)) begin
                  state <= S_DONE;
               end
            end
            S_FLUSH: begin
               if (in_flight == '0) begin
                  state <= S_IDLE;
               end
            end
            S_DONE: begin
               sts_done <= 1'b1;
               state    <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gray_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gray_frame_sequencer
// Self-checking bench for gray_frame_sequencer. Provides a 3-cycle grayscale
// pipe model, runs a table of frames (normal, zero-length, stalled sink,
// start+abort collision) and hand-written abort, restart and mid-frame reset
// sequences. Inputs change on the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_gray_frame_sequencer;

   logic        ACLK = 1'b0;
   logic        ARESETN;
   logic        cfg_start;
   logic        cfg_abort;
   logic [19:0] cfg_num_pixels;
   logic        sts_busy;
   logic        sts_done;
   logic        sts_aborted;
   logic [19:0] sts_out_count;
   logic        irq;
   logic        pipe_in_valid;
   logic [23:0] pipe_in_data;
   logic        pipe_out_valid;
   logic [7:0]  pipe_out_data;

   int vectors;
   int miscompares;

   gray_frame_sequencer_if #(.PIX_W(24), .GRAY_W(8)) bus ();

   gray_frame_sequencer dut (
      .ACLK           (ACLK),
      .ARESETN        (ARESETN),
      .cfg_start      (cfg_start),
      .cfg_abort      (cfg_abort),
      .cfg_num_pixels (cfg_num_pixels),
      .sts_busy       (sts_busy),
      .sts_done       (sts_done),
      .sts_aborted    (sts_aborted),
      .sts_out_count  (sts_out_count),
      .irq            (irq),
      .stream         (bus),
      .pipe_in_valid  (pipe_in_valid),
      .pipe_in_data   (pipe_in_data),
      .pipe_out_valid (pipe_out_valid),
      .pipe_out_data  (pipe_out_data)
   );

   always #5 ACLK = ~ACLK;

   function automatic logic [7:0] gray_of(input logic [23:0] p);
      logic [17:0] acc;
      acc = 18'd77 * {10'd0, p[23:16]} + 18'd150 * {10'd0, p[15:8]} + 18'd29 * {10'd0, p[7:0]};
      return acc[15:8];
   endfunction

   // Three-stage conversion pipe: one output per input, never stalls.
   logic [2:0] pipe_v;
   logic [7:0] pipe_d0, pipe_d1, pipe_d2;
   always @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         pipe_v  <= '0;
         pipe_d0 <= '0;
         pipe_d1 <= '0;
         pipe_d2 <= '0;
      end else begin
         pipe_v  <= {pipe_v[1:0], pipe_in_valid};
         pipe_d0 <= gray_of(pipe_in_data);
         pipe_d1 <= pipe_d0;
         pipe_d2 <= pipe_d1;
      end
   end
   assign pipe_out_valid = pipe_v[2];
   assign pipe_out_data  = pipe_d2;

   function automatic logic [23:0] pixel_at(input int j);
      logic [7:0] b;
      b = 8'(j);
      case (j)
         0:       return 24'hFF0000;
         1:       return 24'h00FF00;
         2:       return 24'h0000FF;
         3:       return 24'hFFFFFF;
         default: return (j < 0) ? 24'h000000 : {b * 8'd37, b ^ 8'h5A, 8'd255 - b};
      endcase
   endfunction

   function automatic logic [7:0] expected_gray(input int j);
      case (j)
         0:       return 8'h4C;
         1:       return 8'h95;
         2:       return 8'h1C;
         3:       return 8'hFF;
         default: return gray_of(pixel_at(j));
      endcase
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   typedef struct {
      logic [19:0] num;
      int          stall;
      logic        abort_with_start;
      int          exp_stall_issued;
      logic        exp_ready_at_stall;
      logic [19:0] exp_out_count;
   } frame_vec_t;

   frame_vec_t table_v [5];
   frame_vec_t restart_v;
   frame_vec_t after_reset_v;

   // One full frame: start in cycle 0, stream pixels, score the sink output.
   task automatic apply_stimulus(input frame_vec_t v);
      int issued = 0;
      int popped = 0;
      int irq_count = 0;
      int irq_cycle = -1;
      int last_pop_cycle = -1;
      int ready_cycles = 0;
      bit finished = 1'b0;
      for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
         @(negedge ACLK);
         cfg_start      = (cyc == 0);
         cfg_abort      = (cyc == 0) && v.abort_with_start;
         cfg_num_pixels = v.num;
         bus.m_ready    = (cyc > v.stall);
         bus.src_valid  = (cyc > 0) && (issued < int'(v.num));
         bus.src_data   = pixel_at(issued);
         #1;
         if (cyc == 1) begin
            check_output("cycle1_done_cleared", sts_done, 1'b0);
            check_output("cycle1_busy", sts_busy, v.num != 0);
            check_output("cycle1_count_cleared", sts_out_count, 0);
         end
         if (bus.src_ready) ready_cycles++;
         if (irq) begin
            irq_count++;
            if (irq_cycle < 0) irq_cycle = cyc;
         end
         if (bus.src_valid && bus.src_ready) issued++;
         if (bus.m_valid && bus.m_ready) begin
            check_output("m_data", bus.m_data, expected_gray(popped));
            check_output("m_last", bus.m_last, popped == int'(v.num) - 1);
            popped++;
            if (popped == int'(v.num)) last_pop_cycle = cyc;
         end
         if (v.stall > 0 && cyc == v.stall) begin
            check_output("stall_issued", issued, v.exp_stall_issued);
            check_output("stall_src_ready", bus.src_ready, v.exp_ready_at_stall);
         end
         if (irq_cycle >= 0 && cyc >= irq_cycle + 2) finished = 1'b1;
      end
      check_output("frame_completed", finished, 1'b1);
      check_output("irq_count", irq_count, 1);
      check_output("irq_cycle", irq_cycle, (v.num == 0) ? 1 : last_pop_cycle + 1);
      check_output("popped", popped, v.exp_out_count);
      check_output("sts_out_count", sts_out_count, v.exp_out_count);
      check_output("sts_done", sts_done, 1'b1);
      check_output("sts_aborted", sts_aborted, 1'b0);
      check_output("sts_busy_end", sts_busy, 1'b0);
      if (v.num == 0) check_output("zero_len_ready", ready_cycles, 0);
      cfg_start = 1'b0;
      cfg_abort = 1'b0;
      bus.src_valid = 1'b0;
   endtask

   // Abort after 6 issues with 3 still in the pipe; a start mid-frame is ignored.
   task automatic abort_sequence();
      int irq_seen = 0;
      int mvalid_seen = 0;
      bit busy_gone = 1'b0;
      for (int cyc = 0; cyc <= 7; cyc++) begin
         @(negedge ACLK);
         cfg_start      = (cyc == 0) || (cyc == 3);
         cfg_num_pixels = (cyc == 3) ? 20'd2 : 20'd16;
         cfg_abort      = (cyc == 7);
         bus.m_ready    = 1'b1;
         bus.src_valid  = (cyc >= 1) && (cyc <= 6);
         bus.src_data   = pixel_at(cyc - 1);
         #1;
         if (cyc >= 1 && cyc <= 6) check_output("abort_run_ready", bus.src_ready, 1'b1);
         if (cyc == 7) check_output("abort_irq", irq, 1'b1);
      end
      @(negedge ACLK);
      cfg_start = 1'b0;
      cfg_abort = 1'b0;
      bus.src_valid = 1'b0;
      #1;
      check_output("abort_m_valid", bus.m_valid, 1'b0);
      check_output("abort_sts_aborted", sts_aborted, 1'b1);
      check_output("abort_flush_busy", sts_busy, 1'b1);
      check_output("abort_src_ready", bus.src_ready, 1'b0);
      for (int cyc = 9; cyc < 30 && !busy_gone; cyc++) begin
         @(negedge ACLK);
         #1;
         if (irq) irq_seen++;
         if (bus.m_valid) mvalid_seen++;
         if (cyc == 9) check_output("abort_busy_while_returning", sts_busy, 1'b1);
         if (!sts_busy) busy_gone = 1'b1;
      end
      check_output("abort_busy_falls", busy_gone, 1'b1);
      check_output("abort_extra_irq", irq_seen, 0);
      check_output("abort_flush_m_valid", mvalid_seen, 0);
      check_output("abort_sts_done", sts_done, 1'b0);
      check_output("abort_sts_aborted_sticky", sts_aborted, 1'b1);
   endtask

   // Reset asserted asynchronously in the middle of a running frame.
   task automatic reset_sequence();
      int issued = 0;
      for (int cyc = 0; cyc <= 8; cyc++) begin
         @(negedge ACLK);
         cfg_start      = (cyc == 0);
         cfg_num_pixels = 20'd10;
         bus.m_ready    = 1'b1;
         bus.src_valid  = (cyc >= 1);
         bus.src_data   = pixel_at(issued);
         #1;
         if (bus.src_valid && bus.src_ready) issued++;
      end
      check_output("pre_reset_busy", sts_busy, 1'b1);
      check_output("pre_reset_out_count", sts_out_count, 3);
      @(negedge ACLK);
      cfg_start = 1'b0;
      bus.src_valid = 1'b0;
      #2;
      ARESETN = 1'b0;
      #1;
      check_output("rst_busy", sts_busy, 1'b0);
      check_output("rst_src_ready", bus.src_ready, 1'b0);
      check_output("rst_m_valid", bus.m_valid, 1'b0);
      check_output("rst_m_last", bus.m_last, 1'b0);
      check_output("rst_m_data", bus.m_data, 0);
      check_output("rst_irq", irq, 1'b0);
      check_output("rst_out_count", sts_out_count, 0);
      check_output("rst_pipe_in_valid", pipe_in_valid, 1'b0);
      @(negedge ACLK);
      @(negedge ACLK);
      ARESETN = 1'b1;
      @(negedge ACLK);
      #1;
      check_output("post_rst_busy", sts_busy, 1'b0);
      check_output("post_rst_count", sts_out_count, 0);
      check_output("post_rst_ready", bus.src_ready, 1'b0);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vectors        = 0;
      miscompares    = 0;
      ARESETN        = 1'b0;
      cfg_start      = 1'b0;
      cfg_abort      = 1'b0;
      cfg_num_pixels = '0;
      bus.src_valid  = 1'b0;
      bus.src_data   = '0;
      bus.m_ready    = 1'b0;

      //              num    stall start+abort stall_issued ready_at_stall out_count
      table_v[0]    = '{20'd4,  0,  1'b0, 0, 1'b0, 20'd4};
      table_v[1]    = '{20'd0,  0,  1'b0, 0, 1'b0, 20'd0};
      table_v[2]    = '{20'd20, 30, 1'b0, 8, 1'b0, 20'd20};
      table_v[3]    = '{20'd1,  0,  1'b1, 0, 1'b0, 20'd1};
      table_v[4]    = '{20'd9,  5,  1'b0, 5, 1'b1, 20'd9};
      restart_v     = '{20'd2,  0,  1'b0, 0, 1'b0, 20'd2};
      after_reset_v = '{20'd3,  0,  1'b0, 0, 1'b0, 20'd3};

      #12;
      check_output("reset_busy", sts_busy, 1'b0);
      check_output("reset_done", sts_done, 1'b0);
      check_output("reset_aborted", sts_aborted, 1'b0);
      check_output("reset_irq", irq, 1'b0);
      check_output("reset_src_ready", bus.src_ready, 1'b0);
      check_output("reset_m_valid", bus.m_valid, 1'b0);
      check_output("reset_out_count", sts_out_count, 0);
      @(negedge ACLK);
      ARESETN = 1'b1;

      for (int i = 0; i < 5; i++) begin
         apply_stimulus(table_v[i]);
      end

      // Abort while idle must be ignored.
      @(negedge ACLK);
      cfg_abort = 1'b1;
      #1;
      check_output("idle_abort_irq", irq, 1'b0);
      @(negedge ACLK);
      cfg_abort = 1'b0;
      #1;
      check_output("idle_abort_sts_aborted", sts_aborted, 1'b0);
      check_output("idle_abort_sts_done", sts_done, 1'b1);

      abort_sequence();
      apply_stimulus(restart_v);
      reset_sequence();
      apply_stimulus(after_reset_v);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
